// File: rtl/lsu_subword.sv
// rtl/lsu_subword.sv - RV32I load/store unit converting byte/half/word accesses to word memory cycles.
// Sub-word stores read-modify-write; faults (misaligned or illegal funct3) skip memory entirely.
module lsu_subword #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  input  logic                     req_we,
  input  logic [2:0]               req_funct3,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     busy,
  output logic                     resp_valid,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     fault,
  output logic                     mem_wr_en,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wd,
  input  logic [DATA_WIDTH-1:0]    mem_rd
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

  state_t                   state_q, state_d;
  logic                     we_q, we_d;
  logic [2:0]               funct3_q, funct3_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0]    merge_q, merge_d;
  logic                     fault_q, fault_d;

  logic                     req_fault;
  logic [7:0]               ld_byte;
  logic [15:0]              ld_half;
  logic [DATA_WIDTH-1:0]    ld_ext;
  logic [DATA_WIDTH-1:0]    st_merged;

  always_comb begin
    req_fault = 1'b0;
    if (req_funct3[1:0] == 2'b01 && req_addr[0])
      req_fault = 1'b1;
    if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
      req_fault = 1'b1;
    if (req_we && req_funct3 > 3'b010)
      req_fault = 1'b1;
    if (!req_we && (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11))
      req_fault = 1'b1;
  end

  // Little-endian lane select; halfword lane is addr[1].
  always_comb begin
    ld_byte = 8'h00;
    case (addr_q[1:0])
      2'b00:   ld_byte = mem_rd[7:0];
      2'b01:   ld_byte = mem_rd[15:8];
      2'b10:   ld_byte = mem_rd[23:16];
      default: ld_byte = mem_rd[31:24];
    endcase
    ld_half = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];
    case (funct3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_ext = mem_rd;
      3'b100:  ld_ext = {24'h000000, ld_byte};
      3'b101:  ld_ext = {16'h0000, ld_half};
      default: ld_ext = '0;
    endcase
  end

  always_comb begin
    st_merged = mem_rd;
    if (funct3_q[1:0] == 2'b00) begin
      case (addr_q[1:0])
        2'b00:   st_merged[7:0]   = wdata_q[7:0];
        2'b01:   st_merged[15:8]  = wdata_q[7:0];
        2'b10:   st_merged[23:16] = wdata_q[7:0];
        default: st_merged[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      st_merged[31:16] = wdata_q[15:0];
    end else begin
      st_merged[15:0] = wdata_q[15:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    merge_d  = merge_q;
    fault_d  = fault_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          rdata_d  = '0;
          merge_d  = '0;
          fault_d  = req_fault;
          if (req_fault)
            state_d = S_RESP;
          else if (req_we && req_funct3 == 3'b010)
            state_d = S_WR;
          else
            state_d = S_RD;
        end
      end
      S_RD: begin
        if (we_q) begin
          merge_d = st_merged;
          state_d = S_WR;
        end else begin
          rdata_d = ld_ext;
          state_d = S_RESP;
        end
      end
      S_WR:    state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      merge_q  <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      merge_q  <= merge_d;
      fault_q  <= fault_d;
    end
  end

  // SW bypasses the merge register since it never reads memory.
  always_comb begin
    busy       = (state_q != S_IDLE);
    resp_valid = (state_q == S_RESP);
    resp_rdata = (state_q == S_RESP) ? rdata_q : '0;
    fault      = (state_q == S_RESP) && fault_q;
    mem_wr_en  = (state_q == S_WR);
    mem_addr   = {2'b00, addr_q[ADDRESS_WIDTH-1:2]};
    mem_wd     = '0;
    if (state_q == S_WR)
      mem_wd = (funct3_q == 3'b010) ? wdata_q : merge_q;
  end

endmodule

// File: tb/tb_lsu_subword.sv
// tb/tb_lsu_subword.sv - directed self-checking bench for lsu_subword with a word memory model.
module tb_lsu_subword;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        busy;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        fault;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] mem [0:255];
  logic        tb_we;
  logic [7:0]  tb_waddr;
  logic [31:0] tb_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] seen_addr;
  logic [31:0] seen_wd;

  always #5 clk = ~clk;

  lsu_subword #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .busy       (busy),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .fault      (fault),
    .mem_wr_en  (mem_wr_en),
    .mem_addr   (mem_addr),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  assign mem_rd = mem[mem_addr[7:0]];

  always @(posedge clk) begin
    if (mem_wr_en)
      mem[mem_addr[7:0]] <= mem_wd;
    else if (tb_we)
      mem[tb_waddr] <= tb_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [31:0] d);
    tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
    @(posedge clk); #1;
    tb_we = 1'b0;
  endtask

  // One request, then watch up to 6 cycles for its response.
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int exp_lat, input logic [31:0] exp_rd,
                        input logic exp_flt, input int exp_wr);
    int lat; int wr; logic [31:0] rd; logic flt;
    lat = 0; wr = 0; rd = '0; flt = 1'b0;
    @(negedge clk);
    chk({tag, " idle"}, {31'd0, busy}, 32'd0);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    seen_addr = mem_addr;
    for (int n = 1; n <= 6 && lat == 0; n++) begin
      @(negedge clk);
      if (mem_wr_en) begin
        wr++;
        seen_wd = mem_wd;
      end
      if (resp_valid) begin
        lat = n; rd = resp_rdata; flt = fault;
      end
    end
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " rdata"}, rd, exp_rd);
    chk({tag, " fault"}, {31'd0, flt}, {31'd0, exp_flt});
    chk({tag, " writes"}, wr, exp_wr);
  endtask

  initial begin
    int cyc_next_idle; int exp_resp_cyc; int accepts; int resps; int kind;
    logic [31:0] exp_rd; logic exp_flt; logic acc_now;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0; tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;
    seen_addr = '0; seen_wd = '0;

    poke(8'd255, 32'h0001_2345);
    poke(8'd4,   32'h1122_3344);
    poke(8'd1,   32'hCAFE_BABE);
    poke(8'd8,   32'hA5A5_A5A5);
    poke(8'd0,   32'h0000_0000);
    @(negedge clk);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst fault", {31'd0, fault}, 32'd0);
    chk("rst mem_wr_en", {31'd0, mem_wr_en}, 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst mem_wd", mem_wd, 32'd0);
    chk("rst resp_rdata", resp_rdata, 32'd0);
    rst_n = 1'b1;

    do_req("lw 3fc", 1'b0, 3'b010, 32'h3FC, 32'h0, 2, 32'h0001_2345, 1'b0, 0);
    chk("lw 3fc mem_addr", seen_addr, 32'hFF);

    do_req("sb 11", 1'b1, 3'b000, 32'h11, 32'hFFFF_FFAB, 3, 32'h0, 1'b0, 1);
    chk("sb 11 mem_wd", seen_wd, 32'h1122_AB44);
    chk("sb 11 mem", mem[4], 32'h1122_AB44);
    do_req("lb 11",  1'b0, 3'b000, 32'h11, 32'h0, 2, 32'hFFFF_FFAB, 1'b0, 0);
    do_req("lbu 11", 1'b0, 3'b100, 32'h11, 32'h0, 2, 32'h0000_00AB, 1'b0, 0);
    do_req("lh 12",  1'b0, 3'b001, 32'h12, 32'h0, 2, 32'h0000_1122, 1'b0, 0);
    do_req("lh 10",  1'b0, 3'b001, 32'h10, 32'h0, 2, 32'hFFFF_AB44, 1'b0, 0);
    do_req("lhu 10", 1'b0, 3'b101, 32'h10, 32'h0, 2, 32'h0000_AB44, 1'b0, 0);

    do_req("sh 06", 1'b1, 3'b001, 32'h06, 32'h1234_BEEF, 3, 32'h0, 1'b0, 1);
    chk("sh 06 mem_wd", seen_wd, 32'hBEEF_BABE);
    do_req("sw 04", 1'b1, 3'b010, 32'h04, 32'h0102_0304, 2, 32'h0, 1'b0, 1);
    chk("sw 04 mem_wd", seen_wd, 32'h0102_0304);
    do_req("lw 04 after sw", 1'b0, 3'b010, 32'h04, 32'h0, 2, 32'h0102_0304, 1'b0, 0);

    do_req("lh 13 misaligned", 1'b0, 3'b001, 32'h13, 32'h0, 1, 32'h0, 1'b1, 0);
    do_req("sw 06 misaligned", 1'b1, 3'b010, 32'h06, 32'hDEAD_BEEF, 1, 32'h0, 1'b1, 0);
    do_req("load f3 011",      1'b0, 3'b011, 32'h00, 32'h0, 1, 32'h0, 1'b1, 0);
    do_req("store f3 100",     1'b1, 3'b100, 32'h10, 32'h0, 1, 32'h0, 1'b1, 0);
    chk("sw 06 untouched", mem[1], 32'h0102_0304);

    // req_valid held high, alternating LW 3fc and a misaligned LH.
    @(negedge clk);
    cyc_next_idle = 0; exp_resp_cyc = -1; accepts = 0; resps = 0; kind = 0;
    exp_rd = '0; exp_flt = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h3FC;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (cyc > 0) @(negedge clk);
      acc_now = (cyc == cyc_next_idle);
      chk("hold busy", {31'd0, busy}, {31'd0, !acc_now});
      chk("hold resp_valid", {31'd0, resp_valid}, {31'd0, cyc == exp_resp_cyc});
      if (resp_valid) begin
        resps++;
        chk("hold rdata", resp_rdata, exp_rd);
        chk("hold fault", {31'd0, fault}, {31'd0, exp_flt});
      end
      if (acc_now) begin
        accepts++;
        exp_rd  = (kind == 0) ? 32'h0001_2345 : 32'h0;
        exp_flt = (kind != 0);
        exp_resp_cyc  = cyc + ((kind == 0) ? 2 : 1);
        cyc_next_idle = exp_resp_cyc + 1;
      end
      @(posedge clk); #1;
      if (acc_now) begin
        kind = 1 - kind;
        req_funct3 = (kind == 0) ? 3'b010 : 3'b001;
        req_addr   = (kind == 0) ? 32'h3FC : 32'h13;
      end
    end
    req_valid = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (resp_valid) resps++;
    end
    chk("hold accepts", accepts, 32'd8);
    chk("hold resp count", resps, accepts);

    // Reset pulse during WR of an SH to word 8.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h22; req_wdata = 32'h0000_7777;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("sh rst in wr", {31'd0, mem_wr_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("sh rst busy", {31'd0, busy}, 32'd0);
    chk("sh rst mem_wr_en", {31'd0, mem_wr_en}, 32'd0);
    chk("sh rst mem_addr", mem_addr, 32'd0);
    chk("sh rst mem_wd", mem_wd, 32'd0);
    chk("sh rst resp_valid", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    resps = 0; accepts = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (resp_valid) resps++;
      if (mem_wr_en) accepts++;
    end
    chk("sh rst no resp", resps, 32'd0);
    chk("sh rst no write", accepts, 32'd0);
    chk("sh rst mem", mem[8], 32'hA5A5_A5A5);
    do_req("lw 20 after rst", 1'b0, 3'b010, 32'h20, 32'h0, 2, 32'hA5A5_A5A5, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_subword.md
# lsu_subword

Load/store unit between the execute stage and the word-wide data memory. It accepts one load or store request at a time and converts RV32I byte, halfword and word accesses into word-indexed memory reads and writes. Sub-word stores use a read-modify-write sequence. Load results are sign- or zero-extended. Misaligned accesses and illegal funct3 codes are reported as a fault and never touch memory. The pipeline stalls on `busy`.

## Interface
- ADDRESS_WIDTH, 32, byte address width of request and memory address.
- DATA_WIDTH, 32, data width; fixed at 32 for the byte-lane logic.
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request strobe; accepted only when `busy`=0.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width code.
- req_addr  in  ADDRESS_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data; the low byte or halfword is used for sub-word stores.
- busy  out  1  high in every state except IDLE.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and faults.
- fault  out  1  valid with `resp_valid`; misaligned access or illegal funct3.
- mem_wr_en  out  1  memory write enable.
- mem_addr  out  ADDRESS_WIDTH  word index, equal to {2'b00, addr[31:2]}.
- mem_wd  out  DATA_WIDTH  memory write data.
- mem_rd  in  DATA_WIDTH  memory read data, combinational from `mem_addr`.

## Operation
- Acceptance: `req_valid` && state==IDLE latches we, funct3, addr and wdata into registers. `req_valid` is ignored while `busy`=1; requests are not queued.
- Loads:
  - 000 LB, 001 LH, 010 LW sign-extend.
  - 100 LBU, 101 LHU zero-extend.
  - All other load codes fault.
- Stores:
  - 000 SB, 001 SH, 010 SW.
  - All other store codes fault.
- Alignment: halfword needs addr[0]=0; word needs addr[1:0]=0. Byte lane is addr[1:0], little-endian: lane 0 = bits 7:0. The halfword lane is addr[1].
- States: IDLE, RD, WR, RESP.
  - IDLE -> RESP on accept if fault.
  - IDLE -> RD on accept for a load, SB or SH.
  - IDLE -> WR on accept for SW.
  - RD -> RESP for a load; `mem_rd` is captured and extended into the result register.
  - RD -> WR for SB/SH; `mem_rd` is captured and the store lane is merged into it.
  - WR -> RESP.
  - RESP -> IDLE.
- mem_wr_en is 1 only in WR. In WR, `mem_wd` is the merged word (SB/SH) or wdata (SW). Outside WR, `mem_wd` = 0.
- mem_addr is driven from the latched address in all states.
- Faulting requests never enter RD or WR.

## Timing
- Cycle 0 is the accept edge. Latency to `resp_valid` is counted in rising edges after acceptance:
  - fault: 1.
  - load: 2.
  - SW: 2.
  - SB/SH: 3.
- resp_valid is high exactly one cycle, in RESP. `resp_rdata` and `fault` are valid in that cycle only and are 0 otherwise.
- The next request can be accepted in the cycle after RESP, when state is IDLE again. The minimum spacing is therefore latency+1 cycles.
- The memory write commits on the rising edge that leaves WR. A load issued immediately afterwards reads the new value.
- Reset (rst_n=0, at any time):
  - state = IDLE.
  - busy, resp_valid, fault, mem_wr_en = 0.
  - mem_addr, mem_wd, resp_rdata and all latched registers = 0.
- Reset asserted in RD or WR aborts the operation: no write is issued after reset deasserts and no `resp_valid` is produced.
- The first accept can occur on the first rising edge with rst_n=1.

## Test plan
- LW, addr 0x3FC, memory word 255 = 0x00012345:
  - mem_addr = 0xFF.
  - resp_valid 2 cycles after accept with rdata 0x00012345 and fault=0.
  - mem_wr_en never high.
- SB, addr 0x11, wdata 0xFFFFFFAB, word 4 initially 0x11223344:
  - RD, then WR with mem_wd 0x1122AB44 and mem_wr_en for exactly 1 cycle.
  - resp_valid 3 cycles after accept.
- Loads from addr 0x11 after that store:
  - LB returns 0xFFFFFFAB.
  - LBU returns 0x000000AB.
  - LH at addr 0x12 returns 0x00001122.
- Faults, each with resp_valid 1 cycle after accept, fault=1, rdata 0, and no mem_wr_en:
  - LH at addr 0x13.
  - SW at addr 0x06.
  - Load with funct3 011.
- req_valid held high continuously with alternating requests:
  - Each request is accepted only in IDLE.
  - Exactly one resp_valid per accepted request.
  - busy is low only in IDLE.
- rst_n pulsed low for 1 cycle while in WR of an SH:
  - Outputs are 0 immediately.
  - Target memory word is unchanged.
  - No resp_valid.
  - A subsequent LW completes normally.
